// File: rtl/dma_w_burst_sched_pkg.sv
// Shared types and constants for the AXI write-side burst scheduler.
package dma_w_burst_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_DONE    = 3'd5
  } sched_state_e;

  // Transfer status codes reported to the CSR block.
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CFG   = 2'b01;
  localparam logic [1:0] ERR_BRESP = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  // AXI bursts may not cross a 4 KB page.
  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_OFF_W = 12;

  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned BURST_W    = 9;
  localparam int unsigned BURSTS_W   = 16;

endpackage

// File: rtl/dma_burst_calc.sv
// Beats for the next burst: min(remaining, MAX_BEATS, beats left in the 4 KB page).
module dma_burst_calc
  import dma_w_burst_sched_pkg::*;
#(
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned BB_LOG2   = 2,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic [PAGE_OFF_W-1:0] page_off,
  input  logic [CNT_W-1:0]      remaining,
  output logic [BURST_W-1:0]    beats_c
);

  // One extra bit so a page-aligned address yields the full 4096 bytes.
  localparam int unsigned SPAN_W = PAGE_OFF_W + 1;

  logic [SPAN_W-1:0] to_4k;
  logic [SPAN_W-1:0] cap;

  // Clamp to the page end first, then to the burst cap, then to what is left.
  always_comb begin
    to_4k   = (SPAN_W'(PAGE_BYTES) - {1'b0, page_off}) >> BB_LOG2;
    cap     = (to_4k < SPAN_W'(MAX_BEATS)) ? to_4k : SPAN_W'(MAX_BEATS);
    beats_c = (remaining < CNT_W'(cap)) ? BURST_W'(remaining) : BURST_W'(cap);
  end

endmodule

// File: rtl/dma_w_burst_sched.sv
// Splits one software write transfer into 4 KB-safe AXI INCR bursts for dma_axi_w.
module dma_w_burst_sched
  import dma_w_burst_sched_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DMA_DATA_W = 32,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MAX_BEATS  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [CNT_W-1:0]     cfg_beats,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [BURSTS_W-1:0]  bursts_issued,
  output logic                 eng_valid,
  output logic [ADDR_W-1:0]    eng_addr,
  output logic [AXI_LEN_W-1:0] eng_len,
  input  logic                 eng_aw_hs,
  input  logic                 eng_dma_ready,
  input  logic                 eng_error
);

  localparam int unsigned BB         = DMA_DATA_W / 8;
  localparam int unsigned BB_LOG2    = $clog2(BB);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BB - 1);

  sched_state_e          state,         state_nxt;
  logic [ADDR_W-1:0]     cur_addr,      cur_addr_nxt;
  logic [CNT_W-1:0]      remaining,     remaining_nxt;
  logic [BURST_W-1:0]    burst_beats,   burst_beats_nxt;
  logic                  abort_pend,    abort_pend_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  err_nxt;
  logic [1:0]            err_code_nxt;
  logic [BURSTS_W-1:0]   bursts_issued_nxt;
  logic                  eng_valid_nxt;
  logic [ADDR_W-1:0]     eng_addr_nxt;
  logic [AXI_LEN_W-1:0]  eng_len_nxt;
  logic [BURST_W-1:0]    calc_beats_c;

  dma_burst_calc #(
    .CNT_W     (CNT_W),
    .BB_LOG2   (BB_LOG2),
    .MAX_BEATS (MAX_BEATS)
  ) u_calc (
    .page_off  (cur_addr[PAGE_OFF_W-1:0]),
    .remaining (remaining),
    .beats_c   (calc_beats_c)
  );

  // State and all registered outputs; reset drops eng_valid without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      burst_beats   <= '0;
      abort_pend    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= ERR_NONE;
      bursts_issued <= '0;
      eng_valid     <= 1'b0;
      eng_addr      <= '0;
      eng_len       <= '0;
    end else begin
      state         <= state_nxt;
      cur_addr      <= cur_addr_nxt;
      remaining     <= remaining_nxt;
      burst_beats   <= burst_beats_nxt;
      abort_pend    <= abort_pend_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
      err_code      <= err_code_nxt;
      bursts_issued <= bursts_issued_nxt;
      eng_valid     <= eng_valid_nxt;
      eng_addr      <= eng_addr_nxt;
      eng_len       <= eng_len_nxt;
    end
  end

  // Next-state and next-output logic; abort is only recorded, never acted on mid-burst.
  always_comb begin
    state_nxt         = state;
    cur_addr_nxt      = cur_addr;
    remaining_nxt     = remaining;
    burst_beats_nxt   = burst_beats;
    abort_pend_nxt    = abort_pend | (abort & (state != ST_IDLE));
    busy_nxt          = busy;
    done_nxt          = 1'b0;
    err_nxt           = err;
    err_code_nxt      = err_code;
    bursts_issued_nxt = bursts_issued;
    eng_valid_nxt     = eng_valid;
    eng_addr_nxt      = eng_addr;
    eng_len_nxt       = eng_len;

    case (state)
      ST_IDLE: begin
        if (start) begin
          cur_addr_nxt      = cfg_addr;
          remaining_nxt     = cfg_beats;
          err_nxt           = 1'b0;
          err_code_nxt      = ERR_NONE;
          bursts_issued_nxt = '0;
          abort_pend_nxt    = 1'b0;
          busy_nxt          = 1'b1;
          if ((cfg_beats == '0) || ((cfg_addr & ALIGN_MASK) != '0)) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_CFG;
            state_nxt    = ST_DONE;
          end else begin
            state_nxt    = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        burst_beats_nxt = calc_beats_c;
        eng_addr_nxt    = cur_addr;
        eng_len_nxt     = AXI_LEN_W'(calc_beats_c - BURST_W'(1));
        if (abort_pend) begin
          err_nxt      = 1'b1;
          err_code_nxt = ERR_ABORT;
          state_nxt    = ST_DONE;
        end else begin
          eng_valid_nxt = 1'b1;
          state_nxt     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (eng_aw_hs) begin
          eng_valid_nxt     = 1'b0;
          bursts_issued_nxt = bursts_issued + BURSTS_W'(1);
          state_nxt         = ST_WAIT_LO;
        end
      end

      // dma_ready is still high from before the handshake; wait for it to drop.
      ST_WAIT_LO: begin
        if (!eng_dma_ready) begin
          state_nxt = ST_WAIT_HI;
        end
      end

      ST_WAIT_HI: begin
        if (eng_dma_ready) begin
          if (eng_error) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_BRESP;
            state_nxt    = ST_DONE;
          end else begin
            cur_addr_nxt  = cur_addr + (ADDR_W'(burst_beats) << BB_LOG2);
            remaining_nxt = remaining - CNT_W'(burst_beats);
            state_nxt     = (remaining == CNT_W'(burst_beats)) ? ST_DONE : ST_CALC;
          end
        end
      end

      ST_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_w_burst_sched.sv
// Directed bench for dma_w_burst_sched with a behavioural engine and burst-list model.
module tb_dma_w_burst_sched;
  import dma_w_burst_sched_pkg::*;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DMA_DATA_W = 32;
  localparam int unsigned CNT_W      = 24;
  localparam int unsigned MAX_BEATS  = 256;
  localparam int unsigned BB         = DMA_DATA_W / 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [ADDR_W-1:0]    cfg_addr = '0;
  logic [CNT_W-1:0]     cfg_beats = '0;
  logic                 busy, done, err;
  logic [1:0]           err_code;
  logic [BURSTS_W-1:0]  bursts_issued;
  logic                 eng_valid;
  logic [ADDR_W-1:0]    eng_addr;
  logic [AXI_LEN_W-1:0] eng_len;
  logic                 eng_aw_hs;
  logic                 eng_dma_ready;
  logic                 eng_error;

  always #5 clk = ~clk;

  dma_w_burst_sched #(
    .ADDR_W(ADDR_W), .DMA_DATA_W(DMA_DATA_W), .CNT_W(CNT_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_beats(cfg_beats),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .bursts_issued(bursts_issued),
    .eng_valid(eng_valid), .eng_addr(eng_addr), .eng_len(eng_len),
    .eng_aw_hs(eng_aw_hs), .eng_dma_ready(eng_dma_ready), .eng_error(eng_error)
  );

  typedef struct {
    longint addr;
    int     len;
  } burst_t;

  burst_t     exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         done_cnt = 0;
  logic       exp_err = 1'b0;
  logic [1:0] exp_code = 2'b00;
  int         exp_bursts = 0;
  int         err_at = -1;
  int         eng_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected burst list from the splitting rules; stop_after<0 means no truncation.
  function automatic int build_model(input logic [31:0] addr, input int beats, input int stop_after);
    longint a;
    int     rem, n, to4k, nb;
    burst_t b;
    exp_q.delete();
    a = longint'(addr);
    rem = beats;
    nb = 0;
    while (rem > 0 && (stop_after < 0 || nb < stop_after)) begin
      to4k = (4096 - int'(a % 4096)) / int'(BB);
      n = rem;
      if (n > int'(MAX_BEATS)) n = int'(MAX_BEATS);
      if (n > to4k) n = to4k;
      b.addr = a;
      b.len = n - 1;
      exp_q.push_back(b);
      a = (a + longint'(n) * longint'(BB)) % 64'd4294967296;
      rem -= n;
      nb++;
    end
    return exp_q.size();
  endfunction

  // Engine model: accepts AW one cycle after valid, then dma_ready low for len+3 cycles.
  initial begin : engine
    int phase;
    int cnt;
    int len_l;
    phase = 0; cnt = 0; len_l = 0;
    eng_aw_hs = 1'b0; eng_dma_ready = 1'b1; eng_error = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        phase = 0; eng_aw_hs = 1'b0; eng_dma_ready = 1'b1; eng_error = 1'b0;
      end else begin
        case (phase)
          0: if (eng_valid) phase = 4;
          4: begin eng_aw_hs = 1'b1; len_l = int'(eng_len); phase = 1; end
          1: begin eng_aw_hs = 1'b0; phase = 2; end
          2: begin eng_dma_ready = 1'b0; eng_error = 1'b0; cnt = len_l + 2; phase = 3; end
          3: begin
            if (cnt == 0) begin
              eng_dma_ready = 1'b1;
              eng_error = (eng_idx == err_at);
              eng_idx++;
              phase = 0;
            end else cnt--;
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // Every cycle: issued bursts must match the model head; done must carry the expected status.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (eng_valid) begin
          if (exp_q.size() == 0) chk("unexpected_burst", 64'(eng_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            chk("eng_addr", 64'(eng_addr), 64'(exp_q[0].addr));
            chk("eng_len", 64'(eng_len), 64'(exp_q[0].len));
            if (eng_aw_hs) void'(exp_q.pop_front());
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_busy", 64'(busy), 64'(0));
          chk("done_err", 64'(err), 64'(exp_err));
          chk("done_code", 64'(err_code), 64'(exp_code));
          chk("done_bursts", 64'(bursts_issued), 64'(exp_bursts));
          chk("done_all_issued", 64'(exp_q.size()), 64'(0));
        end
      end
    end
  end

  task automatic run_xfer(input logic [31:0] addr, input int beats, input int stop_after,
                          input int e_at, input logic e_err, input logic [1:0] e_code,
                          input bit do_abort, input bit abort_with_start, input int exp_lat);
    int d0;
    int lat;
    bit got;
    exp_bursts = build_model(addr, beats, stop_after);
    exp_err = e_err;
    exp_code = e_code;
    err_at = e_at;
    eng_idx = 0;
    d0 = done_cnt;
    @(negedge clk);
    cfg_addr = addr;
    cfg_beats = CNT_W'(beats);
    start = 1'b1;
    abort = abort_with_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    if (do_abort) begin
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
        @(negedge clk);
        if (!eng_dma_ready) got = 1'b1;
      end
      if (!got) chk("abort_wait_timeout", 64'(0), 64'(1));
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk); #1;
      lat++;
      if (done_cnt != d0) got = 1'b1;
    end
    if (!got) chk("done_timeout", 64'(0), 64'(1));
    if (exp_lat >= 0) chk("done_latency", 64'(lat), 64'(exp_lat));
    repeat (3) @(negedge clk);
    #1;
    chk("single_done", 64'(done_cnt - d0), 64'(1));
  endtask

  initial begin : main
    int n;
    bit got;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_code", 64'(err_code), 64'(0));
    chk("rst_bursts", 64'(bursts_issued), 64'(0));
    chk("rst_valid", 64'(eng_valid), 64'(0));
    chk("rst_addr", 64'(eng_addr), 64'(0));
    chk("rst_len", 64'(eng_len), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic split: 600 beats from 0x1000.
    n = build_model(32'h1000, 600, -1);
    chk("pin_basic_n", 64'(n), 64'(3));
    chk("pin_b0_addr", 64'(exp_q[0].addr), 64'h1000);
    chk("pin_b0_len", 64'(exp_q[0].len), 64'd255);
    chk("pin_b1_addr", 64'(exp_q[1].addr), 64'h1400);
    chk("pin_b2_addr", 64'(exp_q[2].addr), 64'h1800);
    chk("pin_b2_len", 64'(exp_q[2].len), 64'd87);
    run_xfer(32'h1000, 600, -1, -1, 1'b0, ERR_NONE, 1'b0, 1'b0, -1);
    chk("basic_bursts", 64'(bursts_issued), 64'd3);
    chk("basic_err", 64'(err), 64'(0));

    // 4 KB crossing.
    n = build_model(32'h0FF0, 10, -1);
    chk("pin_4k_n", 64'(n), 64'(2));
    chk("pin_4k_b0_len", 64'(exp_q[0].len), 64'd3);
    chk("pin_4k_b1_addr", 64'(exp_q[1].addr), 64'h1000);
    chk("pin_4k_b1_len", 64'(exp_q[1].len), 64'd5);
    run_xfer(32'h0FF0, 10, -1, -1, 1'b0, ERR_NONE, 1'b0, 1'b0, -1);

    // Bad configurations: zero beats, then misaligned address.
    run_xfer(32'h1000, 0, 0, -1, 1'b1, ERR_CFG, 1'b0, 1'b0, 2);
    chk("cfg0_code", 64'(err_code), 64'b01);
    run_xfer(32'h1002, 4, 0, -1, 1'b1, ERR_CFG, 1'b0, 1'b0, 2);
    chk("cfg_align_bursts", 64'(bursts_issued), 64'd0);

    // Write-response error on burst 2 of 3.
    run_xfer(32'h2000, 600, 2, 1, 1'b1, ERR_BRESP, 1'b0, 1'b0, -1);
    chk("bresp_bursts", 64'(bursts_issued), 64'd2);
    chk("bresp_code", 64'(err_code), 64'b10);

    // Abort while burst 1 of 4 is in flight.
    run_xfer(32'h0000, 1024, 1, -1, 1'b1, ERR_ABORT, 1'b1, 1'b0, -1);
    chk("abort_bursts", 64'(bursts_issued), 64'd1);
    chk("abort_err", 64'(err), 64'(1));

    // Address wraps past 2^32 at a page boundary.
    n = build_model(32'hFFFF_FFF0, 8, -1);
    chk("pin_wrap_b1_addr", 64'(exp_q[1].addr), 64'h0);
    run_xfer(32'hFFFF_FFF0, 8, -1, -1, 1'b0, ERR_NONE, 1'b0, 1'b0, -1);

    // Abort coincident with start is dropped.
    run_xfer(32'h4000, 20, -1, -1, 1'b0, ERR_NONE, 1'b0, 1'b1, -1);
    chk("start_abort_code", 64'(err_code), 64'b00);

    // Asynchronous reset while a burst is being offered.
    n = build_model(32'h1000, 600, -1);
    err_at = -1;
    eng_idx = 0;
    @(negedge clk);
    cfg_addr = 32'h1000;
    cfg_beats = CNT_W'(600);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (eng_valid) got = 1'b1;
    end
    if (!got) chk("valid_wait_timeout", 64'(0), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(eng_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_bursts", 64'(bursts_issued), 64'(0));
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(32'h1000, 600, -1, -1, 1'b0, ERR_NONE, 1'b0, 1'b0, -1);
    chk("post_rst_bursts", 64'(bursts_issued), 64'd3);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_w_burst_sched.md
Name: dma_w_burst_sched

Overview:
Sequencer in front of the AXI write DMA engine (dma_axi_w). It takes one software transfer command (base address and total beat count) and splits it into legal AXI INCR bursts, capped at MAX_BEATS and never crossing a 4 KB boundary. It issues each burst to the engine's addr/valid/dma_len inputs, tracks burst completion through the engine's dma_ready, and collects a sticky error and done status for the CSR block.

Parameters:
ADDR_W, 32, byte address width; equals the engine ADDR_W.
DMA_DATA_W, 32, beat width in bits; beat bytes BB = DMA_DATA_W/8, a power of two.
CNT_W, 24, width of the total beat count.
MAX_BEATS, 256, maximum beats per burst, range 1..256.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse; accepted only when busy=0.
abort  in  1  single-cycle pulse; sets a pending-abort flag.
cfg_addr  in  ADDR_W  transfer base byte address.
cfg_beats  in  CNT_W  total beats; 0 is illegal.
busy  out  1  high from accepted start until done.
done  out  1  single-cycle pulse at end of transfer, whether ok, error or abort.
err  out  1  sticky; cleared by the next accepted start.
err_code  out  2  00 none, 01 bad config, 10 bresp error, 11 aborted.
bursts_issued  out  16  number of bursts issued for the current transfer.
eng_valid  out  1  drives the engine valid input.
eng_addr  out  ADDR_W  drives the engine addr input.
eng_len  out  `AXI_LEN_W  drives the engine dma_len input (beats-1).
eng_aw_hs  in  1  m_axi_awvalid & m_axi_awready, tapped at the engine.
eng_dma_ready  in  1  engine dma_ready output.
eng_error  in  1  engine error output.

Behaviour:
- Reset values: busy, done, err and eng_valid = 0; err_code = 00; bursts_issued = 0; eng_addr = 0; eng_len = 0; FSM in IDLE.
- Registers: cur_addr (ADDR_W), remaining (CNT_W), burst_beats (9 bits), abort_pend.
- IDLE:
  - On start, latch cfg_addr and cfg_beats; clear err, err_code, bursts_issued and abort_pend; set busy.
  - If cfg_beats==0 or cfg_addr[log2(BB)-1:0]!=0: go to DONE with err=1, code 01. No burst is issued.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - to_4k = (4096 - cur_addr[11:0]) >> log2(BB).
  - burst_beats = min(remaining, MAX_BEATS, to_4k).
  - eng_addr = cur_addr; eng_len = burst_beats-1.
  - If abort_pend: go to DONE with err=1, code 11. Otherwise go to ISSUE.
- ISSUE:
  - eng_valid=1; eng_addr and eng_len are held stable.
  - On eng_aw_hs: eng_valid=0 in the next cycle, bursts_issued+1, go to WAIT_LO.
  - abort is not honoured mid-handshake.
- WAIT_LO: wait for eng_dma_ready==0. This skips the stale registered high.
- WAIT_HI: wait for eng_dma_ready==1, which means the engine has returned to idle and the response is in. Then sample eng_error:
  - If 1: err=1, code 10, go to DONE.
  - Else: cur_addr += burst_beats*BB; remaining -= burst_beats.
    - remaining==0 -> DONE.
    - Otherwise -> CALC (abort_pend is checked there).
- DONE: done=1 for 1 cycle, busy=0, go to IDLE.
  - The earliest next start is accepted in the cycle after done.
- start while busy is ignored. abort while idle is ignored. abort during ISSUE/WAIT lets the current burst finish, then the transfer stops.
- Boundary cases:
  - An address exactly on a 4 KB boundary gives to_4k=4096/BB.
  - cur_addr wraps modulo 2^ADDR_W with no error.
- Simultaneous start and abort in IDLE: start is taken and abort is dropped.
- rst_n asserted mid-burst drops eng_valid immediately; the engine is reset by the same rst_n.
- Throughput overhead: 3 cycles per burst (CALC, WAIT_LO entry, WAIT_HI exit) plus engine time.

Decomposition:
- Shared package/header (dma_sched.vh, alongside axi.vh):
  - FSM state codes: IDLE, CALC, ISSUE, WAIT_LO, WAIT_HI, DONE (3 bits).
  - err_code constants.
  - 4 KB page constant.
- One sub-module, dma_burst_calc: purely combinational min(remaining, MAX_BEATS, to_4k). It is reused later by the read-side scheduler.

Test Plan:
- Basic split: start addr 0x1000, beats 600, BB=4, engine model ok -> 3 bursts, eng_len 255, 255, 87 at 0x1000, 0x1400, 0x1800; one done pulse; err=0.
- 4 KB crossing: addr 0x0FF0, beats 10 -> burst len 3 at 0x0FF0, then len 5 at 0x1000.
- Bad config: beats 0, then addr 0x1002 -> no eng_valid; done 2 cycles after start; err=1, code 01.
- Bresp error: engine raises error after burst 2 of 3 -> burst 3 not issued; code 10; bursts_issued=2.
- Abort: abort during WAIT_HI of burst 1 of 4 -> burst 1 completes; done; code 11; bursts_issued=1.
- Async reset: rst_n low during ISSUE -> eng_valid drops without a clock; busy=0; a new start after release works.
